// File: rtl/mac_feeder.sv
// -----------------------------------------------------------------------------
// mac_feeder
//
// Initiator-side sequencer for one MAC unit in the matrix-vector datapath.
// It accepts a job (start + len) and clears the MAC accumulator. It then
// streams len operand pairs from a valid/ready source onto the MAC En/Ain/Bin
// pins. A zero-operand flush beat follows, so the product held in the MAC's
// one-stage product register is added and the register is reloaded with 0.
// Finally the dot product is returned on a valid/ready result port.
//
// Ports
//   clk        clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   start      job request, sampled only in IDLE
//   len        number of operand pairs, captured together with start
//   busy       high in every state except IDLE
//   in_valid   operand pair valid
//   in_ready   feeder accepts the pair this cycle (state RUN)
//   a_in/b_in  operand pair
//   mac_en     MAC enable (registered)
//   mac_clr    MAC accumulator clear (registered)
//   mac_a/b    MAC operands (registered, forced to 0 whenever mac_en is 0)
//   mac_cout   MAC accumulator value
//   res_valid  result valid (registered)
//   res_ready  result consumer ready
//   res_data   captured dot product (registered, held while res_valid)
// -----------------------------------------------------------------------------
module mac_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   a_in,
  input  logic [DATA_WIDTH-1:0]   b_in,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3*DATA_WIDTH-1:0] res_data
);

  localparam int RES_WIDTH = 3 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                  state_q,     state_d;
  logic [LEN_WIDTH-1:0]    len_q,       len_d;
  logic [LEN_WIDTH-1:0]    cnt_q,       cnt_d;
  logic                    mac_en_q,    mac_en_d;
  logic                    mac_clr_q,   mac_clr_d;
  logic [DATA_WIDTH-1:0]   mac_a_q,     mac_a_d;
  logic [DATA_WIDTH-1:0]   mac_b_q,     mac_b_d;
  logic                    res_valid_q, res_valid_d;
  logic [RES_WIDTH-1:0]    res_data_q,  res_data_d;

  logic [LEN_WIDTH-1:0]    cnt_inc;
  logic                    in_hs;

  assign cnt_inc  = cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  assign in_ready = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign in_hs    = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic.
  //
  // MAC pipeline timing (one product stage):
  //   cycle L   : last pair handshake in RUN
  //   cycle L+1 : last pair on MAC pins (state FLUSH issues the flush beat)
  //   cycle L+2 : flush beat 0/0 on MAC pins (state WAIT); the MAC adds the
  //               last product at the end of this cycle
  //   cycle L+3 : mac_cout is final; first DONE cycle captures it
  //   cycle L+4 : res_valid high with the captured value
  // For a zero-length job there is no pending pair, so CLEAR issues the flush
  // beat itself and goes straight to WAIT. The clear and the flush then land
  // in consecutive cycles and the result appears 4 cycles after start.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mac_en_d    = 1'b0;
    mac_clr_d   = 1'b0;
    mac_a_d     = '0;
    mac_b_d     = '0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = len;
          cnt_d     = '0;
          mac_clr_d = 1'b1;
          state_d   = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (len_q != '0) begin
          state_d = S_RUN;
        end else begin
          // Zero-length job: the flush beat follows the clear directly.
          mac_en_d = 1'b1;
          state_d  = S_WAIT;
        end
      end

      S_RUN: begin
        if (in_hs) begin
          mac_en_d = 1'b1;
          mac_a_d  = a_in;
          mac_b_d  = b_in;
          cnt_d    = cnt_inc;
          // Compare against the captured length, not the live len input.
          if (cnt_inc == len_q) begin
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        // Zero operands: adds the last product and leaves the product stage
        // at 0, so the next job starts from a clean pipeline.
        mac_en_d = 1'b1;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        if (!res_valid_q) begin
          // First DONE cycle: the flush add has landed in mac_cout.
          res_valid_d = 1'b1;
          res_data_d  = mac_cout;
        end else if (res_ready) begin
          // start is deliberately not looked at here.
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_feeder.sv
// -----------------------------------------------------------------------------
// tb_mac_feeder
//
// Bench for mac_feeder. A behavioural MAC (product stage + accumulator) sits
// on the MAC pins. Jobs come from a vector table and from random stimulus.
// Expected dot products are plain sums of a*b computed here. A negedge monitor
// tallies handshakes, clear pulses and enable beats for per-job checks.
// -----------------------------------------------------------------------------
module tb_mac_feeder;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int RW = 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a_in, b_in;
  logic          mac_en, mac_clr;
  logic [DW-1:0] mac_a, mac_b;
  logic [RW-1:0] mac_cout;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_data;

  always #5 clk = ~clk;

  mac_feeder #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_cout  (mac_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  // Downstream MAC: product of the En-cycle operands goes into a product
  // stage; each En cycle adds the previously held product. Clr zeroes only
  // the accumulator.
  logic [RW-1:0] mac_acc, mac_prod;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_acc  <= '0;
      mac_prod <= '0;
    end else begin
      if (mac_clr)     mac_acc <= '0;
      else if (mac_en) mac_acc <= mac_acc + mac_prod;
      if (mac_en)      mac_prod <= RW'(mac_a) * RW'(mac_b);
    end
  end
  assign mac_cout = mac_acc;

  // Cycle index: after posedge k (plus #1) cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor tallies.
  int hs_tot = 0, clr_tot = 0, en_tot = 0, zviol_tot = 0, clr_cyc = 0;
  logic [DW-1:0] last_en_a = '0, last_en_b = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) hs_tot <= hs_tot + 1;
      if (mac_clr) begin
        clr_tot <= clr_tot + 1;
        clr_cyc <= cyc;
      end
      if (mac_en) begin
        en_tot    <= en_tot + 1;
        last_en_a <= mac_a;
        last_en_b <= mac_b;
      end else if ((mac_a != '0) || (mac_b != '0)) begin
        zviol_tot <= zviol_tot + 1;
      end
    end
  end

  int    checks = 0;
  int    errors = 0;
  string cur_tag = "";

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d, expected %0d", cur_tag, name, act, exp);
    end
  endtask

  logic [DW-1:0] job_a [16];
  logic [DW-1:0] job_b [16];

  // Runs one job from job_a/job_b and checks result, latency and MAC traffic.
  task automatic run_job(input int n, input int gap, input int hold,
                         input logic [RW-1:0] exp_res);
    int hs0, clr0, en0, zv0;
    int start_cyc, last_acc, rv_cyc;
    logic [RW-1:0] held;
    bit got;
    hs0 = hs_tot; clr0 = clr_tot; en0 = en_tot; zv0 = zviol_tot;
    rv_cyc = 0;

    @(posedge clk); #1;
    start = 1'b1;
    len = LW'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    len = LW'($urandom);   // live len changes must not matter
    last_acc = start_cyc;

    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      a_in = job_a[i];
      b_in = job_b[i];
      got = 1'b0;
      for (int t = 0; t < 32 && !got; t++) begin
        @(negedge clk);
        if (in_ready) begin
          got = 1'b1;
          last_acc = cyc;
        end
        @(posedge clk); #1;
      end
      chk("accept_timeout", 64'(got), 64'd1);
      in_valid = 1'b0;
      a_in = DW'($urandom);
      b_in = DW'($urandom);
    end

    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        rv_cyc = cyc;
      end
    end
    chk("res_timeout", 64'(got), 64'd1);
    chk("latency", 64'(rv_cyc - last_acc), 64'd4);
    chk("res_data", 64'(res_data), 64'(exp_res));
    held = res_data;

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      start = (h == 1);
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", 64'(res_data), 64'(held));
      chk("hold_busy", 64'(busy), 64'd1);
    end

    // Handshake; a start in the same cycle must be ignored.
    res_ready = 1'b1;
    start = (hold > 0);
    @(posedge clk); #1;
    res_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("valid_drop", 64'(res_valid), 64'd0);
    chk("idle_after", 64'(busy), 64'd0);
    chk("data_after", 64'(res_data), 64'(held));

    chk("handshakes", 64'(hs_tot - hs0), 64'(n));
    chk("clr_pulses", 64'(clr_tot - clr0), 64'd1);
    chk("clr_cycle", 64'(clr_cyc - start_cyc), 64'd1);
    chk("en_beats", 64'(en_tot - en0), 64'(n + 1));
    chk("flush_ops", 64'({last_en_a, last_en_b}), 64'd0);
    chk("zero_when_idle", 64'(zviol_tot - zv0), 64'd0);
    $display("job %-10s len=%0d gap=%0d hold=%0d res=%0d exp=%0d", cur_tag, n, gap, hold,
             held, exp_res);
  endtask

  typedef struct {
    string           name;
    int              len;
    int              gap;
    int              hold;
    logic [2:0][7:0] a;
    logic [2:0][7:0] b;
    logic [RW-1:0]   exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{name:"basic",   len:3, gap:0, hold:0, a:{8'd6, 8'd4, 8'd2},
                b:{8'd7, 8'd5, 8'd3}, exp:24'd68};
    vecs[1] = '{name:"stall",   len:3, gap:2, hold:0, a:{8'd6, 8'd4, 8'd2},
                b:{8'd7, 8'd5, 8'd3}, exp:24'd68};
    vecs[2] = '{name:"b2b_max", len:2, gap:0, hold:0, a:{8'd0, 8'd255, 8'd255},
                b:{8'd0, 8'd255, 8'd255}, exp:24'd130050};
    vecs[3] = '{name:"b2b_one", len:1, gap:0, hold:0, a:{8'd0, 8'd0, 8'd1},
                b:{8'd0, 8'd0, 8'd1}, exp:24'd1};
    vecs[4] = '{name:"len0",    len:0, gap:0, hold:0, a:'0, b:'0, exp:24'd0};
    vecs[5] = '{name:"hold",    len:3, gap:1, hold:5, a:{8'd6, 8'd4, 8'd2},
                b:{8'd7, 8'd5, 8'd3}, exp:24'd68};

    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    a_in = '0; b_in = '0; res_ready = 1'b0;

    cur_tag = "reset";
    @(negedge clk);
    chk("state_outs", 64'({busy, in_ready, mac_en, mac_clr, res_valid}), 64'd0);
    chk("mac_ops", 64'({mac_a, mac_b}), 64'd0);
    chk("res_data", 64'(res_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cur_tag = vecs[i].name;
      for (int j = 0; j < 3; j++) begin
        job_a[j] = vecs[i].a[j];
        job_b[j] = vecs[i].b[j];
      end
      run_job(vecs[i].len, vecs[i].gap, vecs[i].hold, vecs[i].exp);
    end

    // Reset in the middle of RUN after one of three pairs.
    cur_tag = "mid_reset";
    @(posedge clk); #1;
    start = 1'b1; len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; a_in = 8'd9; b_in = 8'd9;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_in_run", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("en_before_rst", 64'(mac_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_outs", 64'({busy, in_ready, mac_en, mac_clr, res_valid, mac_a, mac_b, res_data}),
        64'd0);
    @(negedge clk);
    chk("held_outs", 64'({busy, in_ready, mac_en, mac_clr, res_valid, mac_a, mac_b, res_data}),
        64'd0);
    rst_n = 1'b1;
    cur_tag = "after_rst";
    job_a[0] = 8'd3; job_b[0] = 8'd3;
    run_job(1, 0, 0, 24'd9);

    // Randomized jobs against a plain sum-of-products reference.
    for (int r = 0; r < 10; r++) begin
      int n, g, h;
      logic [RW-1:0] exp_sum;
      n = $urandom_range(0, 7);
      g = $urandom_range(0, 2);
      h = $urandom_range(0, 2);
      exp_sum = '0;
      for (int j = 0; j < n; j++) begin
        job_a[j] = DW'($urandom);
        job_b[j] = DW'($urandom);
        exp_sum = exp_sum + RW'(job_a[j]) * RW'(job_b[j]);
      end
      cur_tag = $sformatf("rand%0d", r);
      run_job(n, g, h, exp_sum);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
